// File: rtl/fetch_queue_unit.sv
// Fetch stage: issues sequential instruction-memory reads and queues {instr, pc, pc_next} for decode.
// Latency: request in cycle N, pushed at end of N+1, out_valid in N+2 when the queue was empty.
// Backpressure: out_valid/out_ready; issue is credit-limited so count + inflight never exceeds QDEPTH.
//
// Ports:
//   clk, reset                    rising-edge clock, synchronous active-low reset
//   imem_req, imem_addr           fetch request strobe and address (address = fetch PC)
//   imem_rdata                    instruction word, valid one cycle after imem_req
//   redirect_valid, redirect_pc   flush queue, kill in-flight fetch, restart at redirect_pc
//   out_valid, out_ready          decode handshake on the queue head
//   out_instr, out_pc, out_pc_next  head entry (zero when the queue is empty)
//   perf_stall_cycles, perf_redirects  saturating counters, present only with FETCH_QUEUE_PERF_EN
//
// Optional feature macro: FETCH_QUEUE_PERF_EN
// QDEPTH must be a power of two and >= 2 so the pointers wrap naturally.
module fetch_queue_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] PC_RESET = '0,
  parameter logic [XLEN-1:0] PC_STEP  = XLEN'(4),
  parameter int unsigned     QDEPTH   = 4
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_pc_next
`ifdef FETCH_QUEUE_PERF_EN
  ,
  output logic [31:0]     perf_stall_cycles,
  output logic [31:0]     perf_redirects
`endif
);

  localparam int unsigned   PW    = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned   CW    = PW + 1;
  localparam logic [CW-1:0] DEPTH = CW'(QDEPTH);

  // Fetch state
  logic [XLEN-1:0] fetch_pc_q,    fetch_pc_d;
  logic            inflight_q,    inflight_d;
  logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;

  // Queue control
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q,  count_d;

  // Queue storage (not reset; the head outputs are gated by out_valid)
  logic [XLEN-1:0] instr_q   [QDEPTH];
  logic [XLEN-1:0] instr_d   [QDEPTH];
  logic [XLEN-1:0] pc_q      [QDEPTH];
  logic [XLEN-1:0] pc_d      [QDEPTH];
  logic [XLEN-1:0] pc_next_q [QDEPTH];
  logic [XLEN-1:0] pc_next_d [QDEPTH];

  logic [CW-1:0]   used;
  logic            issue;
  logic            push;
  logic            pop;

  // Credit check: entries held plus the one that may land next cycle.
  // A pop in the same cycle is deliberately not credited, keeping the
  // issue path independent of out_ready.
  always_comb begin
    used  = count_q + CW'(inflight_q);
    issue = reset & ~redirect_valid & (used < DEPTH);
  end

  assign imem_req  = issue;
  assign imem_addr = fetch_pc_q;

  assign out_valid = (count_q != '0);
  assign pop       = out_valid & out_ready;
  // Every in-flight request returns exactly one word next cycle.
  assign push      = inflight_q;

  always_comb begin
    out_instr   = '0;
    out_pc      = '0;
    out_pc_next = '0;
    if (out_valid) begin
      out_instr   = instr_q[rd_ptr_q];
      out_pc      = pc_q[rd_ptr_q];
      out_pc_next = pc_next_q[rd_ptr_q];
    end
  end

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = issue;
    inflight_pc_d = inflight_pc_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    instr_d       = instr_q;
    pc_d          = pc_q;
    pc_next_d     = pc_next_q;

    if (redirect_valid) begin
      // Redirect wins over push and pop: the returning word (if any) is
      // from the old path and is dropped by clearing inflight.
      fetch_pc_d = redirect_pc;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (push) begin
        instr_d[wr_ptr_q]   = imem_rdata;
        pc_d[wr_ptr_q]      = inflight_pc_q;
        pc_next_d[wr_ptr_q] = inflight_pc_q + PC_STEP;
        wr_ptr_d            = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      if (issue) begin
        fetch_pc_d    = fetch_pc_q + PC_STEP;
        inflight_pc_d = fetch_pc_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc_q    <= PC_RESET;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    instr_q   <= instr_d;
    pc_q      <= pc_d;
    pc_next_q <= pc_next_d;
  end

`ifdef FETCH_QUEUE_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] redir_cnt_q, redir_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    redir_cnt_d = redir_cnt_q;
    if (out_valid && !out_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    if (redirect_valid && (redir_cnt_q != 32'hFFFF_FFFF)) begin
      redir_cnt_d = redir_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      redir_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      redir_cnt_q <= redir_cnt_d;
    end
  end

  assign perf_stall_cycles = stall_cnt_q;
  assign perf_redirects    = redir_cnt_q;
`endif

  // Held entries plus the outstanding request never exceed the queue size,
  // which is what makes the unconditional push safe.
  a_credit_bound: assert property (@(posedge clk) disable iff (!reset) used <= DEPTH);

endmodule

// File: tb/tb_fetch_queue_unit.sv
module tb_fetch_queue_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Main DUT (default parameters)
  logic        reset = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr, out_pc, out_pc_next;

  // Second DUT with PC_RESET near the top of the address space
  logic        w_reset = 1'b0;
  logic        w_imem_req;
  logic [31:0] w_imem_addr;
  logic [31:0] w_imem_rdata = 32'h0;
  logic        w_redirect_valid = 1'b0;
  logic [31:0] w_redirect_pc = 32'h0;
  logic        w_out_valid;
  logic        w_out_ready = 1'b1;
  logic [31:0] w_out_instr, w_out_pc, w_out_pc_next;

`ifdef FETCH_QUEUE_PERF_EN
  logic [31:0] perf_stall_cycles, perf_redirects;
  logic [31:0] w_perf_stall_cycles, w_perf_redirects;
`endif

  fetch_queue_unit dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .out_pc_next(out_pc_next)
`ifdef FETCH_QUEUE_PERF_EN
    , .perf_stall_cycles(perf_stall_cycles), .perf_redirects(perf_redirects)
`endif
  );

  fetch_queue_unit #(.PC_RESET(32'hFFFF_FFF8)) dut_w (
    .clk(clk), .reset(w_reset),
    .imem_req(w_imem_req), .imem_addr(w_imem_addr), .imem_rdata(w_imem_rdata),
    .redirect_valid(w_redirect_valid), .redirect_pc(w_redirect_pc),
    .out_valid(w_out_valid), .out_ready(w_out_ready),
    .out_instr(w_out_instr), .out_pc(w_out_pc), .out_pc_next(w_out_pc_next)
`ifdef FETCH_QUEUE_PERF_EN
    , .perf_stall_cycles(w_perf_stall_cycles), .perf_redirects(w_perf_redirects)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference model: the queue holds the PCs of fetched words; the word and
  // pc_next follow from the PC because the memory returns 0x1000_0000 + addr.
  logic [31:0] mq[$];
  logic [31:0] m_pc      = 32'h0;
  bit          m_infl    = 1'b0;
  logic [31:0] m_infl_pc = 32'h0;
  logic [31:0] m_stall   = 32'h0;
  logic [31:0] m_redir   = 32'h0;

  // Instruction memory environments (1-cycle read latency)
  bit          pend = 1'b0, w_pend = 1'b0;
  logic [31:0] pend_addr = 32'h0, w_pend_addr = 32'h0;
  bit          w_run = 1'b1;

  task automatic step(input bit rst_n_v, input bit rv, input logic [31:0] rpc, input bit rdy);
    bit exp_req;
    @(negedge clk);
    imem_rdata     = pend   ? 32'h1000_0000 + pend_addr   : $urandom;
    w_imem_rdata   = w_pend ? 32'h1000_0000 + w_pend_addr : $urandom;
    reset          = rst_n_v;
    w_reset        = rst_n_v & w_run;
    redirect_valid = rv;
    redirect_pc    = rpc;
    out_ready      = rdy;
    #1;
    exp_req = rst_n_v && !rv && ((mq.size() + int'(m_infl)) < 4);
    chk("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
    if (exp_req) chk("imem_addr", imem_addr, m_pc);
    chk("out_valid", {31'b0, out_valid}, {31'b0, mq.size() != 0});
    if (mq.size() != 0) begin
      chk("out_pc", out_pc, mq[0]);
      chk("out_pc_next", out_pc_next, mq[0] + 32'd4);
      chk("out_instr", out_instr, 32'h1000_0000 + mq[0]);
    end
`ifdef FETCH_QUEUE_PERF_EN
    chk("perf_stall", perf_stall_cycles, m_stall);
    chk("perf_redir", perf_redirects, m_redir);
`endif
    pend        = imem_req;
    pend_addr   = imem_addr;
    w_pend      = w_imem_req;
    w_pend_addr = w_imem_addr;

    // Model update for the coming rising edge
    if (!rst_n_v) begin
      m_stall = 32'h0;
      m_redir = 32'h0;
    end else begin
      if (mq.size() != 0 && !rdy && m_stall != 32'hFFFF_FFFF) m_stall++;
      if (rv && m_redir != 32'hFFFF_FFFF) m_redir++;
    end
    if (!rst_n_v) begin
      mq.delete();
      m_infl = 1'b0;
      m_pc   = 32'h0;
    end else if (rv) begin
      mq.delete();
      m_infl = 1'b0;
      m_pc   = rpc;
    end else begin
      if (mq.size() != 0 && rdy) void'(mq.pop_front());
      if (m_infl) mq.push_back(m_infl_pc);
      if (exp_req) begin
        m_infl_pc = m_pc;
        m_infl    = 1'b1;
        m_pc      = m_pc + 32'd4;
      end else begin
        m_infl = 1'b0;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got no end of test, expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] wexp;
    bit          seen;

    // Reset: everything quiet and zero
    step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_out_pc_next", out_pc_next, 32'h0);
    chk("rst_out_instr", out_instr, 32'h0);
    chk("rst_w_req", {31'b0, w_imem_req}, 32'h0);

    // Release with out_ready high; the wrap DUT runs alongside
    for (int k = 0; k < 8; k++) begin
      step(1'b1, 1'b0, 32'h0, 1'b1);
      wexp = 32'hFFFF_FFF8 + 32'(4 * k);
      chk("w_req", {31'b0, w_imem_req}, 32'h1);
      chk("w_addr", w_imem_addr, wexp);
      if (k >= 2) begin
        wexp = 32'hFFFF_FFF8 + 32'(4 * (k - 2));
        chk("w_out_valid", {31'b0, w_out_valid}, 32'h1);
        chk("w_out_pc", w_out_pc, wexp);
        chk("w_out_pc_next", w_out_pc_next, wexp + 32'd4);
        chk("w_out_instr", w_out_instr, 32'h1000_0000 + wexp);
      end else begin
        chk("w_out_valid", {31'b0, w_out_valid}, 32'h0);
      end
      if (k == 2) chk("first_out_pc", out_pc, 32'h0);
    end
    w_run = 1'b0;

    // Stall from reset for 10 cycles: queue fills, issue stops, head holds
    step(1'b0, 1'b0, 32'h0, 1'b0);
    for (int k = 0; k < 10; k++) step(1'b1, 1'b0, 32'h0, 1'b0);
    chk("stall_req_off", {31'b0, imem_req}, 32'h0);
    chk("stall_head", out_pc, 32'h0);
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1'b0, 32'h0, 1'b1);
      chk("drain_order", out_pc, 32'(4 * k));
    end

    // Redirect with three entries queued and one request in flight
    step(1'b1, 1'b1, 32'h100, 1'b0);
    for (int i = 0; i < 20 && !(mq.size() == 3 && m_infl); i++) step(1'b1, 1'b0, 32'h0, 1'b0);
    chk("reach_3_inflight", {31'b0, (mq.size() == 3 && m_infl)}, 32'h1);
    step(1'b1, 1'b1, 32'h200, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b1);
    chk("redir_out_valid", {31'b0, out_valid}, 32'h0);
    chk("redir_addr", imem_addr, 32'h200);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      step(1'b1, 1'b0, 32'h0, 1'b1);
      seen = out_valid;
    end
    chk("redir_seen", {31'b0, seen}, 32'h1);
    chk("redir_first_pc", out_pc, 32'h200);

    // Redirect in the same cycle as a pop and a push
    step(1'b1, 1'b0, 32'h0, 1'b1);
    chk("pre_pop_push", {31'b0, (mq.size() != 0 && m_infl)}, 32'h1);
    step(1'b1, 1'b1, 32'h300, 1'b1);
    step(1'b1, 1'b0, 32'h0, 1'b1);
    chk("ppr_out_valid", {31'b0, out_valid}, 32'h0);
    chk("ppr_addr", imem_addr, 32'h300);
    step(1'b1, 1'b0, 32'h0, 1'b1);
    chk("ppr_empty", {31'b0, out_valid}, 32'h0);

    // Reset for one cycle with the queue full
    for (int i = 0; i < 20 && mq.size() != 4; i++) step(1'b1, 1'b0, 32'h0, 1'b0);
    chk("reach_full", mq.size(), 32'd4);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b1);
    chk("mrst_out_valid", {31'b0, out_valid}, 32'h0);
    chk("mrst_addr", imem_addr, 32'h0);
`ifdef FETCH_QUEUE_PERF_EN
    chk("mrst_perf_stall", perf_stall_cycles, 32'h0);
    chk("mrst_perf_redir", perf_redirects, 32'h0);
`endif

    // Randomised traffic against the model
    for (int i = 0; i < 2000; i++) begin
      bit          r_rst, r_rv, r_rdy;
      logic [31:0] r_pc;
      r_rst = ($urandom_range(0, 63) != 0);
      r_rv  = ($urandom_range(0, 15) == 0);
      r_rdy = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 3) == 0) r_pc = 32'hFFFF_FFF0 + 32'(4 * $urandom_range(0, 3));
      else                           r_pc = $urandom;
      step(r_rst, r_rv, r_pc, r_rdy);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_queue_unit.md
Name: fetch_queue_unit

Overview:
- Parametrised successor to the single-cycle fetch stage.
- Holds the fetch PC and issues sequential requests to a synchronous instruction memory with 1-cycle read latency.
- Buffers returned {instr, pc, pc_next} in a QDEPTH-entry FIFO and hands them to decode over a valid/ready handshake.
- Accepts a redirect (branch/jump) that flushes the FIFO and kills any in-flight fetch.

Parameters:
- XLEN, 32, PC/instruction width in bits.
- PC_RESET, 0, PC value loaded on reset.
- PC_STEP, 4, increment between sequential fetches.
- QDEPTH, 4, FIFO entries; power of 2, >= 2.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset (0 = reset)
- imem_req  out  1  fetch request strobe this cycle
- imem_addr  out  XLEN  fetch address (= fetch PC)
- imem_rdata  in  XLEN  instruction word; valid exactly 1 cycle after imem_req
- redirect_valid  in  1  redirect request
- redirect_pc  in  XLEN  redirect target
- out_valid  out  1  FIFO head valid
- out_ready  in  1  decode accepts head
- out_instr  out  XLEN  head instruction
- out_pc  out  XLEN  head PC (pc_current)
- out_pc_next  out  XLEN  head PC + PC_STEP (pc_next)

Behaviour:
- Reset (sampled at posedge, reset=0):
  - fetch_pc = PC_RESET; FIFO empty; in-flight flag cleared.
  - out_valid = 0; imem_req = 0; out_instr/out_pc/out_pc_next = 0.
- State:
  - fetch_pc.
  - inflight flag plus inflight_pc, marking a request issued last cycle.
  - FIFO storage, rd_ptr, wr_ptr, count (0..QDEPTH).
- Issue rule:
  - imem_req = reset & ~redirect_valid & (count + inflight < QDEPTH).
  - Credit check ignores a same-cycle pop (conservative).
  - imem_addr = fetch_pc combinationally.
  - On issue: fetch_pc += PC_STEP (mod 2^XLEN, wraps silently); inflight <= 1; inflight_pc <= fetch_pc.
- Response:
  - When inflight = 1, the next posedge pushes {imem_rdata, inflight_pc, inflight_pc + PC_STEP}.
  - The credit rule guarantees no overflow.
- Latency: request in cycle N, push at end of N+1, out_valid = 1 in N+2 if the FIFO was empty.
- Throughput: 1 instruction/cycle sustained when out_ready is held high.
- Handshake:
  - Pop occurs when out_valid & out_ready.
  - Head outputs stay stable while out_valid & ~out_ready.
  - Push and pop in the same cycle leave count unchanged.
  - Pop from empty FIFO is ignored.
- Redirect (redirect_valid = 1 at posedge):
  - FIFO cleared (count = 0, pointers = 0); inflight cleared, so any response arriving next cycle is dropped.
  - fetch_pc = redirect_pc; no request in the redirect cycle; first request from redirect_pc in the next cycle.
  - out_valid = 0 from the next cycle.
  - Redirect has priority over pop and push in the same cycle.
  - Back-to-back redirects: the last one wins.
- Wrap: pointers are log2(QDEPTH) bits and wrap naturally; full = (count == QDEPTH); empty = (count == 0).
- Reset mid-operation: identical to power-on reset; in-flight data discarded.

Optional Feature:
- Macro: FETCH_QUEUE_PERF_EN.
- Defined: adds outputs perf_stall_cycles[31:0] and perf_redirects[31:0].
  - perf_stall_cycles counts cycles with out_valid & ~out_ready.
  - perf_redirects counts cycles with redirect_valid.
  - Both reset to 0 and saturate at 0xFFFFFFFF.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset then release, out_ready = 1, imem returns 0x1000_0000 + addr:
  - imem_addr sequence 0x0, 0x4, 0x8…
  - first out_valid 2 cycles after release with out_pc = 0x0, out_pc_next = 0x4, out_instr = 0x1000_0000.
  - one output per cycle thereafter.
- out_ready = 0 for 10 cycles:
  - count reaches 4 (QDEPTH); imem_req stops once count + inflight = 4.
  - head holds out_pc = 0x0; release drains 0x0, 0x4, 0x8, 0xC in order with no loss or duplication.
- Redirect to 0x200 while FIFO holds 3 entries and a request is in flight:
  - next cycle out_valid = 0; next imem_addr = 0x200.
  - first output out_pc = 0x200; no stale PC ever appears.
- Redirect asserted in the same cycle as a pop and a push: FIFO empty after; redirect target fetched; count = 0.
- PC_RESET = 0xFFFF_FFF8: sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0 (wrap); out_pc_next for 0xFFFF_FFFC = 0x0.
- reset = 0 for one cycle mid-stream with FIFO full:
  - out_valid = 0 next cycle; refetch from PC_RESET.
  - with FETCH_QUEUE_PERF_EN defined, both counters read 0.
